reg_read_scoreboard: RTL

//   Issue-stage controller for the 32-entry register-file read path. Tracks outstanding writes per

---
 rtl/reg_read_scoreboard_pkg.sv | 19 +
 rtl/reg_read_scoreboard_if.sv | 41 ++++
 rtl/reg_read_scoreboard_sb_counter.sv | 44 ++++
 rtl/reg_read_scoreboard.sv | 95 +++++++++
 4 files changed

// File: rtl/reg_read_scoreboard_pkg.sv
// Shared register-file definitions for the read-path scoreboard.
//   NREGS      number of architectural registers
//   REG_ADDR_W register address width
//   REG_ZERO   hardwired-zero register, never tracked
package reg_read_scoreboard_pkg;

    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    // Register 0 is constant, so it never participates in hazard tracking.
    function automatic logic is_tracked(reg_addr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_read_scoreboard_if.sv
// Decode/writeback/read-select bundle for reg_read_scoreboard.
//   master: decode side (drives issue_*, wb_*, flush; observes ready/rsel/status)
//   slave : scoreboard side
//   Signals: issue_valid/ready/rs1/rs2/use_rs2/wr/rd, wb_valid/wb_rd, flush,
//            rsel_a/rsel_b/rsel_valid, busy_vec, err_underflow, stall_cycles.
interface reg_read_scoreboard_if
    import reg_read_scoreboard_pkg::*;
#(
    parameter int unsigned STALL_W = 16
) ();

    logic                 issue_valid;
    logic                 issue_ready;
    reg_addr_t            issue_rs1;
    reg_addr_t            issue_rs2;
    logic                 issue_use_rs2;
    logic                 issue_wr;
    reg_addr_t            issue_rd;
    logic                 wb_valid;
    reg_addr_t            wb_rd;
    logic                 flush;
    reg_addr_t            rsel_a;
    reg_addr_t            rsel_b;
    logic                 rsel_valid;
    logic [NREGS-1:0]     busy_vec;
    logic                 err_underflow;
    logic [STALL_W-1:0]   stall_cycles;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs2, issue_wr, issue_rd,
        output wb_valid, wb_rd, flush,
        input  issue_ready, rsel_a, rsel_b, rsel_valid, busy_vec, err_underflow, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs2, issue_wr, issue_rd,
        input  wb_valid, wb_rd, flush,
        output issue_ready, rsel_a, rsel_b, rsel_valid, busy_vec, err_underflow, stall_cycles
    );

endinterface

// File: rtl/reg_read_scoreboard_sb_counter.sv
// Per-register pending-write counter.
//   clk, reset : clock, synchronous active-high reset
//   inc, dec   : count up / down; both together leave the count unchanged
//   clr        : synchronous clear (flush)
//   nonzero    : at least one write outstanding
//   full       : count at its maximum, 2**CNT_W-1
// The caller guarantees inc only when !full and dec only when nonzero.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic nonzero,
    output logic full
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero = (cnt_q != '0);
    assign full    = (cnt_q == '1);

endmodule

// File: rtl/reg_read_scoreboard.sv
// Issue-stage scoreboard for the 32-entry register-file read path.
//   clk, reset : clock, synchronous active-high reset (dominates everything)
//   bus        : slave side of reg_read_scoreboard_if
// Tracks outstanding writes per register, stalls issue on RAW hazards or a full
// pending-write counter, and registers the read-select addresses for the
// register read muxes. Hazard checks use registered counts only (no wb bypass).
module reg_read_scoreboard
    import reg_read_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STALL_W = 16
) (
    input logic                 clk,
    input logic                 reset,
    reg_read_scoreboard_if.slave bus
);

    logic [NREGS-1:0] nz;
    logic [NREGS-1:0] full;
    logic [NREGS-1:1] inc;
    logic [NREGS-1:1] dec;

    logic rs1_ok, rs2_ok, rd_ok, ready, fire, wb_ok, err_d;

    reg_addr_t          rsel_a_q, rsel_b_q;
    logic               rsel_valid_q;
    logic               err_q;
    logic [STALL_W-1:0] stall_q;

    assign nz[0]   = 1'b0;
    assign full[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (inc[r]),
            .dec     (dec[r]),
            .clr     (bus.flush),
            .nonzero (nz[r]),
            .full    (full[r])
        );
    end

    always_comb begin
        rs1_ok = !is_tracked(bus.issue_rs1) || !nz[bus.issue_rs1];
        rs2_ok = !bus.issue_use_rs2 || !is_tracked(bus.issue_rs2) || !nz[bus.issue_rs2];
        rd_ok  = !bus.issue_wr || !is_tracked(bus.issue_rd) || !full[bus.issue_rd];
        ready  = !bus.flush && rs1_ok && rs2_ok && rd_ok;
        fire   = bus.issue_valid && ready;
        // A writeback coinciding with flush is discarded.
        wb_ok  = bus.wb_valid && !bus.flush;
        err_d  = err_q || (wb_ok && is_tracked(bus.wb_rd) && !nz[bus.wb_rd]);
    end

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < NREGS; r++) begin
            inc[r] = fire && bus.issue_wr && (bus.issue_rd == REG_ADDR_W'(r));
            dec[r] = wb_ok && (bus.wb_rd == REG_ADDR_W'(r)) && nz[r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsel_a_q     <= REG_ZERO;
            rsel_b_q     <= REG_ZERO;
            rsel_valid_q <= 1'b0;
            err_q        <= 1'b0;
            stall_q      <= '0;
        end else begin
            rsel_valid_q <= fire;
            if (fire) begin
                rsel_a_q <= bus.issue_rs1;
                rsel_b_q <= bus.issue_use_rs2 ? bus.issue_rs2 : REG_ZERO;
            end
            err_q <= err_d;
            if (bus.issue_valid && !ready && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end

    assign bus.issue_ready   = ready;
    assign bus.rsel_a        = rsel_a_q;
    assign bus.rsel_b        = rsel_b_q;
    assign bus.rsel_valid    = rsel_valid_q;
    assign bus.busy_vec      = nz;
    assign bus.err_underflow = err_q;
    assign bus.stall_cycles  = stall_q;

endmodule
